spi_sample_rx: RTL



---
 rtl/spi_sample_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_sample_rx.sv
// rtl/spi_sample_rx.sv - SPI slave receiver for packed 2-bit I/Q sample words
module spi_sample_rx #(
   parameter int WORD_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 MCU_CLK_25_000,
   input  logic                 RESET_N,
   input  logic                 MCU_SCK,
   input  logic                 MCU_SS,
   input  logic                 MCU_MOSI,
   output logic [WORD_BITS-1:0] RX_DATA,
   output logic                 RX_VALID,
   input  logic                 RX_READY,
   output logic                 OVERRUN,
   output logic                 FRAME_ERR,
   output logic [15:0]          WORD_COUNT,
   input  logic                 CLEAR_STATUS
);

   localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_d;
   logic                   sync_sck;
   logic                   sync_ss;
   logic                   sync_mosi;
   logic                   sck_rise;

   logic [WORD_BITS-1:0]   shift_reg;
   logic [WORD_BITS-1:0]   shift_nxt;
   logic [CW-1:0]          bitcnt;

   logic                   shift_en;
   logic                   word_done;
   logic                   frame_set;
   logic                   cnt_clr;
   logic                   load;

   assign sync_sck  = sck_sync[SYNC_STAGES-1];
   assign sync_ss   = ss_sync[SYNC_STAGES-1];
   assign sync_mosi = mosi_sync[SYNC_STAGES-1];
   assign sck_rise  = sync_sck & ~sck_d;
   assign shift_nxt = {shift_reg[WORD_BITS-2:0], sync_mosi};
   // A finished word is taken if the output slot is empty or being emptied this cycle
   assign load      = word_done & (~RX_VALID | RX_READY);

   // Synchronize the asynchronous SPI lines; SS idles high so its chain presets to 1
   always_ff @(posedge MCU_CLK_25_000) begin
      if (!RESET_N) begin
         sck_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], MCU_SCK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], MCU_SS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MCU_MOSI};
         sck_d     <= sync_sck;
      end
   end

   // State register
   always_ff @(posedge MCU_CLK_25_000) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: selection level alone moves between IDLE and ACTIVE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!sync_ss) state_nxt = S_ACTIVE;
         S_ACTIVE: if (sync_ss)  state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State outputs: deselection takes priority over a coincident SCK edge
   always_comb begin
      shift_en  = 1'b0;
      word_done = 1'b0;
      frame_set = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         S_IDLE: cnt_clr = 1'b1;
         S_ACTIVE: begin
            if (sync_ss) begin
               cnt_clr   = 1'b1;
               frame_set = (bitcnt != '0);
            end else if (sck_rise) begin
               shift_en  = 1'b1;
               word_done = (bitcnt == LAST_BIT);
            end
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   // Deserializer: shift MSB first, bit counter wraps at each completed word
   always_ff @(posedge MCU_CLK_25_000) begin
      if (!RESET_N) begin
         shift_reg <= '0;
         bitcnt    <= '0;
      end else begin
         if (cnt_clr) begin
            bitcnt <= '0;
         end else if (shift_en) begin
            bitcnt <= word_done ? '0 : bitcnt + 1'b1;
         end
         if (shift_en) begin
            shift_reg <= shift_nxt;
         end
      end
   end

   // Output word holding register and valid/ready handshake
   always_ff @(posedge MCU_CLK_25_000) begin
      if (!RESET_N) begin
         RX_DATA  <= '0;
         RX_VALID <= 1'b0;
      end else begin
         if (load) begin
            RX_DATA  <= shift_nxt;
            RX_VALID <= 1'b1;
         end else if (RX_VALID && RX_READY) begin
            RX_VALID <= 1'b0;
         end
      end
   end

   // Sticky status and word counter; a coincident set or increment beats CLEAR_STATUS
   always_ff @(posedge MCU_CLK_25_000) begin
      if (!RESET_N) begin
         OVERRUN    <= 1'b0;
         FRAME_ERR  <= 1'b0;
         WORD_COUNT <= '0;
      end else begin
         if (word_done && !load) begin
            OVERRUN <= 1'b1;
         end else if (CLEAR_STATUS) begin
            OVERRUN <= 1'b0;
         end

         if (frame_set) begin
            FRAME_ERR <= 1'b1;
         end else if (CLEAR_STATUS) begin
            FRAME_ERR <= 1'b0;
         end

         if (load) begin
            if (CLEAR_STATUS) begin
               WORD_COUNT <= 16'd1;
            end else if (WORD_COUNT != 16'hFFFF) begin
               WORD_COUNT <= WORD_COUNT + 16'd1;
            end
         end else if (CLEAR_STATUS) begin
            WORD_COUNT <= '0;
         end
      end
   end

endmodule
